// File: rtl/dyt_pkg.sv
// Shared constants and types for the dyt operand-fetch stage.
package dyt_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CTRL_W   = 16;

  // Operand source, lowest to highest bypass priority.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/dyt_operand_fetch_if.sv
// Decode-side and execute-side handshakes of the operand-fetch stage.
interface dyt_operand_fetch_if;
  import dyt_pkg::*;

  // Decode -> operand fetch
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic [ADDR_W-1:0] dec_rd;
  logic              dec_wen;
  logic              dec_is_load;
  logic [XLEN-1:0]   dec_imm;
  logic [XLEN-1:0]   dec_pc;
  logic [CTRL_W-1:0] dec_ctrl;

  // Operand fetch -> execute
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [ADDR_W-1:0] out_rd;
  logic              out_wen;
  logic              out_is_load;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;

  // Surrounding pipeline: drives decode fields and execute back-pressure.
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_wen, dec_is_load, dec_imm, dec_pc, dec_ctrl, out_ready,
    input  dec_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_wen,
           out_is_load, out_imm, out_pc, out_ctrl
  );

  // The operand-fetch stage itself.
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_wen, dec_is_load, dec_imm, dec_pc, dec_ctrl, out_ready,
    output dec_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_wen,
           out_is_load, out_imm, out_pc, out_ctrl
  );

endinterface

// File: rtl/dyt_fwd_mux.sv
// Per-source bypass select and load-use hazard detection.
module dyt_fwd_mux
  import dyt_pkg::*;
(
  input  logic [ADDR_W-1:0] i_rs,
  input  logic              i_use,
  input  logic [XLEN-1:0]   i_rf_data,
  // Instruction currently in the output slot (in EX next)
  input  logic              i_slot_valid,
  input  logic              i_slot_wen,
  input  logic              i_slot_is_load,
  input  logic [ADDR_W-1:0] i_slot_rd,
  input  logic [XLEN-1:0]   i_ex_data,
  input  logic              i_mem_wen,
  input  logic [ADDR_W-1:0] i_mem_rd,
  input  logic              i_mem_data_vld,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic [XLEN-1:0]   o_data,
  output logic              o_hazard
);

  logic     w_nonzero;
  logic     w_ex_hit;
  logic     w_mem_hit;
  logic     w_wb_hit;
  fwd_sel_t w_sel;

  assign w_nonzero = (i_rs != '0);
  assign w_ex_hit  = i_slot_valid & i_slot_wen & (i_slot_rd == i_rs);
  assign w_mem_hit = i_mem_wen & (i_mem_rd == i_rs);
  // RF read-during-write returns the old value, so WB must be bypassed too.
  assign w_wb_hit  = i_wb_en & (i_wb_addr == i_rs);

  // Pick the youngest producer whose value is already available.
  always_comb begin
    w_sel = FWD_RF;
    if (w_ex_hit && !i_slot_is_load) begin
      w_sel = FWD_EX;
    end else if (w_mem_hit && i_mem_data_vld) begin
      w_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      w_sel = FWD_WB;
    end
  end

  // Steer the chosen source; x0 always reads as zero.
  always_comb begin
    o_data = i_rf_data;
    unique case (w_sel)
      FWD_EX:  o_data = i_ex_data;
      FWD_MEM: o_data = i_mem_data;
      FWD_WB:  o_data = i_wb_data;
      default: o_data = i_rf_data;
    endcase
    if (!w_nonzero) begin
      o_data = '0;
    end
  end

  // Stall while the producer is a load not yet returned (in EX or pending in MEM).
  always_comb begin
    o_hazard = i_use & w_nonzero &
               ((w_ex_hit & i_slot_is_load) | (w_mem_hit & ~i_mem_data_vld));
  end

endmodule

// File: rtl/dyt_operand_fetch.sv
// Operand-fetch stage: register file addressing, bypass, load-use stall and
// the valid/ready output slot feeding execute.
module dyt_operand_fetch
  import dyt_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dyt_operand_fetch_if.slave  io_if,
  output logic [ADDR_W-1:0]   o_rf_a_addr,
  output logic [ADDR_W-1:0]   o_rf_b_addr,
  input  logic [XLEN-1:0]     i_rf_a_data,
  input  logic [XLEN-1:0]     i_rf_b_data,
  input  logic [XLEN-1:0]     i_ex_res_data,
  input  logic                i_mem_wen,
  input  logic [ADDR_W-1:0]   i_mem_rd,
  input  logic                i_mem_data_vld,
  input  logic [XLEN-1:0]     i_mem_data,
  input  logic                i_wb_en,
  input  logic [ADDR_W-1:0]   i_wb_addr,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_flush
);

  logic              w_adv;
  logic              w_hazard_a;
  logic              w_hazard_b;
  logic              w_hazard;
  logic              w_accept;
  logic [XLEN-1:0]   w_rs1_data;
  logic [XLEN-1:0]   w_rs2_data;

  logic              r_valid;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [ADDR_W-1:0] r_rd;
  logic              r_wen;
  logic              r_is_load;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic [CTRL_W-1:0] r_ctrl;

  assign o_rf_a_addr = io_if.dec_rs1;
  assign o_rf_b_addr = io_if.dec_rs2;

  dyt_fwd_mux u_fwd_a (
    .i_rs           (io_if.dec_rs1),
    .i_use          (io_if.dec_use_rs1),
    .i_rf_data      (i_rf_a_data),
    .i_slot_valid   (r_valid),
    .i_slot_wen     (r_wen),
    .i_slot_is_load (r_is_load),
    .i_slot_rd      (r_rd),
    .i_ex_data      (i_ex_res_data),
    .i_mem_wen      (i_mem_wen),
    .i_mem_rd       (i_mem_rd),
    .i_mem_data_vld (i_mem_data_vld),
    .i_mem_data     (i_mem_data),
    .i_wb_en        (i_wb_en),
    .i_wb_addr      (i_wb_addr),
    .i_wb_data      (i_wb_data),
    .o_data         (w_rs1_data),
    .o_hazard       (w_hazard_a)
  );

  dyt_fwd_mux u_fwd_b (
    .i_rs           (io_if.dec_rs2),
    .i_use          (io_if.dec_use_rs2),
    .i_rf_data      (i_rf_b_data),
    .i_slot_valid   (r_valid),
    .i_slot_wen     (r_wen),
    .i_slot_is_load (r_is_load),
    .i_slot_rd      (r_rd),
    .i_ex_data      (i_ex_res_data),
    .i_mem_wen      (i_mem_wen),
    .i_mem_rd       (i_mem_rd),
    .i_mem_data_vld (i_mem_data_vld),
    .i_mem_data     (i_mem_data),
    .i_wb_en        (i_wb_en),
    .i_wb_addr      (i_wb_addr),
    .i_wb_data      (i_wb_data),
    .o_data         (w_rs2_data),
    .o_hazard       (w_hazard_b)
  );

  // Slot may move when empty or when EX takes it; flush always drains decode.
  assign w_adv           = ~r_valid | io_if.out_ready;
  assign w_hazard        = w_hazard_a | w_hazard_b;
  assign io_if.dec_ready = i_flush | (w_adv & ~w_hazard);
  assign w_accept        = io_if.dec_valid & io_if.dec_ready & ~i_flush;

  // Output slot: flush kills, advance loads or bubbles, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
      r_wen      <= 1'b0;
      r_is_load  <= 1'b0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_ctrl     <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_rd       <= io_if.dec_rd;
        r_wen      <= io_if.dec_wen;
        r_is_load  <= io_if.dec_is_load;
        r_imm      <= io_if.dec_imm;
        r_pc       <= io_if.dec_pc;
        r_ctrl     <= io_if.dec_ctrl;
      end
    end
  end

  assign io_if.out_valid    = r_valid;
  assign io_if.out_rs1_data = r_rs1_data;
  assign io_if.out_rs2_data = r_rs2_data;
  assign io_if.out_rd       = r_rd;
  assign io_if.out_wen      = r_wen;
  assign io_if.out_is_load  = r_is_load;
  assign io_if.out_imm      = r_imm;
  assign io_if.out_pc       = r_pc;
  assign io_if.out_ctrl     = r_ctrl;

endmodule

// File: tb/tb_dyt_operand_fetch.sv
// Bench for dyt_operand_fetch: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a behavioural model.
module tb_dyt_operand_fetch;
  import dyt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dyt_operand_fetch_if bus ();

  logic [ADDR_W-1:0] rf_a_addr, rf_b_addr, mem_rd, wb_addr;
  logic [XLEN-1:0]   rf_a_data, rf_b_data, ex_res_data, mem_data, wb_data;
  logic              mem_wen, mem_data_vld, wb_en, flush;

  dyt_operand_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .io_if          (bus),
    .o_rf_a_addr    (rf_a_addr),
    .o_rf_b_addr    (rf_b_addr),
    .i_rf_a_data    (rf_a_data),
    .i_rf_b_data    (rf_b_data),
    .i_ex_res_data  (ex_res_data),
    .i_mem_wen      (mem_wen),
    .i_mem_rd       (mem_rd),
    .i_mem_data_vld (mem_data_vld),
    .i_mem_data     (mem_data),
    .i_wb_en        (wb_en),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .i_flush        (flush)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_dec(input int vld, input int rs1, input int rs2, input int u1,
                           input int u2, input int rd, input int wen, input int ld,
                           input int imm, input int pc, input int ctrl);
    bus.dec_valid   = 1'(vld);
    bus.dec_rs1     = 4'(rs1);
    bus.dec_rs2     = 4'(rs2);
    bus.dec_use_rs1 = 1'(u1);
    bus.dec_use_rs2 = 1'(u2);
    bus.dec_rd      = 4'(rd);
    bus.dec_wen     = 1'(wen);
    bus.dec_is_load = 1'(ld);
    bus.dec_imm     = 32'(imm);
    bus.dec_pc      = 32'(pc);
    bus.dec_ctrl    = 16'(ctrl);
  endtask

  task automatic idle();
    drive_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    rf_a_data = '0; rf_b_data = '0; ex_res_data = '0;
    mem_wen = 1'b0; mem_rd = '0; mem_data_vld = 1'b0; mem_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  // Directed vectors, one clock each, applied back-to-back after reset.
  typedef struct {
    int vld, rs1, rs2, u1, u2, rd, wen, ld;
    int rfa, rfb, ex;
    int mwen, mrd, mvld, mdata;
    int wben, wbaddr, wbdata;
    int ordy, fl;
    int e_rdy, e_vld, e_d1, e_d2;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  // Behavioural model state
  logic [XLEN-1:0] regs[NUM_REGS];
  bit              m_valid;
  int              m_rd, m_wen, m_ld;
  logic [XLEN-1:0] m_imm, m_pc, m_d1, m_d2;
  logic [15:0]     m_ctrl;

  // Operand value by the bypass rules: newest available producer wins.
  function automatic logic [31:0] resolve(input int rs, input logic [31:0] rf_val);
    if (rs == 0) return 32'h0;
    if (m_valid && m_wen != 0 && m_rd == rs && m_ld == 0) return ex_res_data;
    if (mem_wen && int'(mem_rd) == rs && mem_data_vld) return mem_data;
    if (wb_en && int'(wb_addr) == rs) return wb_data;
    return rf_val;
  endfunction

  function automatic bit waits_on(input int rs, input int use_rs);
    if (use_rs == 0 || rs == 0) return 1'b0;
    if (m_valid && m_wen != 0 && m_ld != 0 && m_rd == rs) return 1'b1;
    return mem_wen && int'(mem_rd) == rs && !mem_data_vld;
  endfunction

  initial begin
    vec_t v;
    //          vld rs1 rs2 u1 u2 rd wen ld  rfa     rfb      ex      mwen mrd mvld mdata
    //          wben wba wbd     ordy fl  rdy vld d1   d2
    vecs[0]  = '{1, 3, 0, 1, 0, 1, 1, 0, 'h11, 'h99, 0, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 1, 1, 'h11, 0};
    vecs[1]  = '{1, 2, 4, 1, 1, 5, 1, 0, 'h22, 'h44, 'h1234, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 1, 1, 'h22, 'h44};
    vecs[2]  = '{1, 5, 5, 1, 1, 8, 1, 0, 0, 0, 'hAA, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 1, 1, 'hAA, 'hAA};
    vecs[3]  = '{1, 0, 0, 0, 0, 6, 1, 1, 'h5, 'h6, 'hEE, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{1, 6, 1, 1, 1, 9, 1, 0, 0, 0, 'hEE, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 6, 0, 1, 0, 9, 1, 0, 0, 'h6, 0, 1, 6, 1, 'h55,
                 0, 0, 0, 1, 0, 1, 1, 'h55, 0};
    vecs[6]  = '{1, 0, 7, 1, 1, 10, 0, 0, 'hDEAD, 0, 0, 0, 0, 0, 0,
                 1, 7, 'h77, 1, 0, 1, 1, 0, 'h77};
    vecs[7]  = '{1, 0, 10, 1, 1, 11, 1, 0, 'h33, 'h1010, 'hBAD, 0, 0, 0, 0,
                 1, 0, 'h5A, 1, 0, 1, 1, 0, 'h1010};
    vecs[8]  = '{1, 11, 11, 1, 1, 13, 0, 0, 'h4, 'h4, 'hE1, 1, 11, 1, 'h2,
                 1, 11, 'h3, 1, 0, 1, 1, 'hE1, 'hE1};
    vecs[9]  = '{1, 11, 11, 1, 1, 14, 1, 0, 'h4, 'h4, 'hE1, 1, 11, 1, 'h22,
                 1, 11, 'h33, 1, 0, 1, 1, 'h22, 'h22};
    vecs[10] = '{1, 2, 0, 1, 0, 3, 1, 0, 'h77, 0, 0, 1, 2, 0, 'h9,
                 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 2, 0, 0, 0, 0, 0, 0, 'h77, 0, 0, 1, 2, 0, 'h9,
                 0, 0, 0, 1, 0, 1, 1, 'h77, 0};
    vecs[12] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 1, 0, 0, 0};
    vecs[13] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 1, 1, 1, 0, 0, 0};

    // Reset state
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset out_rs1_data", bus.out_rs1_data, 0);
    chk("reset out_rs2_data", bus.out_rs2_data, 0);
    chk("reset out_rd", 32'(bus.out_rd), 0);
    chk("reset out_wen", 32'(bus.out_wen), 0);
    chk("reset out_is_load", 32'(bus.out_is_load), 0);
    chk("reset out_imm", bus.out_imm, 0);
    chk("reset out_pc", bus.out_pc, 0);
    chk("reset out_ctrl", 32'(bus.out_ctrl), 0);
    chk("reset dec_ready", 32'(bus.dec_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      v = vecs[i];
      drive_dec(v.vld, v.rs1, v.rs2, v.u1, v.u2, v.rd, v.wen, v.ld,
                'h1000 + i, 4 * i, 'hA500 + i);
      rf_a_data = 32'(v.rfa); rf_b_data = 32'(v.rfb); ex_res_data = 32'(v.ex);
      mem_wen = 1'(v.mwen); mem_rd = 4'(v.mrd); mem_data_vld = 1'(v.mvld);
      mem_data = 32'(v.mdata);
      wb_en = 1'(v.wben); wb_addr = 4'(v.wbaddr); wb_data = 32'(v.wbdata);
      bus.out_ready = 1'(v.ordy); flush = 1'(v.fl);
      #1;
      chk($sformatf("vec%0d dec_ready", i), 32'(bus.dec_ready), 32'(v.e_rdy));
      chk($sformatf("vec%0d rf_a_addr", i), 32'(rf_a_addr), 32'(v.rs1));
      chk($sformatf("vec%0d rf_b_addr", i), 32'(rf_b_addr), 32'(v.rs2));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(v.e_vld));
      if (v.e_vld != 0) begin
        chk($sformatf("vec%0d rs1_data", i), bus.out_rs1_data, 32'(v.e_d1));
        chk($sformatf("vec%0d rs2_data", i), bus.out_rs2_data, 32'(v.e_d2));
        chk($sformatf("vec%0d rd", i), 32'(bus.out_rd), 32'(v.rd));
        chk($sformatf("vec%0d wen", i), 32'(bus.out_wen), 32'(v.wen));
        chk($sformatf("vec%0d is_load", i), 32'(bus.out_is_load), 32'(v.ld));
        chk($sformatf("vec%0d imm", i), bus.out_imm, 32'('h1000 + i));
        chk($sformatf("vec%0d pc", i), bus.out_pc, 32'(4 * i));
        chk($sformatf("vec%0d ctrl", i), 32'(bus.out_ctrl), 32'('hA500 + i));
      end
    end

    // Back-pressure: slot holds for 3 cycles, pending instruction enters on release
    @(negedge clk);
    idle();
    drive_dec(1, 1, 0, 1, 0, 2, 1, 0, 'hA0, 'h200, 'h5A5A);
    rf_a_data = 32'h100;
    @(posedge clk);
    #1;
    chk("bp first valid", 32'(bus.out_valid), 1);
    chk("bp first rs1", bus.out_rs1_data, 32'h100);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_dec(1, 3, 0, 1, 0, 4, 1, 0, 'hB0, 'h204, 'h1234);
    rf_a_data = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp hold%0d dec_ready", k), 32'(bus.dec_ready), 0);
      @(posedge clk);
      #1;
      chk($sformatf("bp hold%0d valid", k), 32'(bus.out_valid), 1);
      chk($sformatf("bp hold%0d imm", k), bus.out_imm, 32'hA0);
      chk($sformatf("bp hold%0d pc", k), bus.out_pc, 32'h200);
      chk($sformatf("bp hold%0d rs1", k), bus.out_rs1_data, 32'h100);
      chk($sformatf("bp hold%0d ctrl", k), 32'(bus.out_ctrl), 32'h5A5A);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release dec_ready", 32'(bus.dec_ready), 1);
    @(posedge clk);
    #1;
    chk("bp release valid", 32'(bus.out_valid), 1);
    chk("bp release imm", bus.out_imm, 32'hB0);
    chk("bp release rs1", bus.out_rs1_data, 32'h300);

    // Flush during a load-use stall
    @(negedge clk);
    idle();
    drive_dec(1, 0, 0, 0, 0, 6, 1, 1, 'hC0, 'h300, 0);
    @(posedge clk);
    #1;
    chk("fl load valid", 32'(bus.out_valid), 1);
    chk("fl load is_load", 32'(bus.out_is_load), 1);
    @(negedge clk);
    drive_dec(1, 6, 0, 1, 0, 7, 1, 0, 'hC4, 'h304, 0);
    #1;
    chk("fl stall dec_ready", 32'(bus.dec_ready), 0);
    flush = 1'b1;
    #1;
    chk("fl flush dec_ready", 32'(bus.dec_ready), 1);
    @(posedge clk);
    #1;
    chk("fl flush out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("fl no spurious issue", 32'(bus.out_valid), 0);

    // Asynchronous reset with a stalled, full slot
    @(negedge clk);
    drive_dec(1, 0, 0, 0, 0, 1, 1, 0, 'hD0, 'h400, 0);
    @(posedge clk);
    #1;
    chk("ar slot valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b0;
    #1;
    chk("ar full dec_ready", 32'(bus.dec_ready), 0);
    rst = 1'b0;
    #1;
    chk("ar out_valid", 32'(bus.out_valid), 0);
    chk("ar out_imm", bus.out_imm, 0);
    chk("ar dec_ready", 32'(bus.dec_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Random traffic against the behavioural model
    m_valid = 1'b0;
    m_rd = 0; m_wen = 0; m_ld = 0;
    m_imm = '0; m_pc = '0; m_ctrl = '0; m_d1 = '0; m_d2 = '0;
    for (int r = 0; r < NUM_REGS; r++) regs[r] = $urandom;
    for (int c = 0; c < 600; c++) begin
      int rs1, rs2, u1, u2, dv, exp_rdy;
      bit stall, can_move, take;
      logic [31:0] d1, d2, imm, pc;
      logic [15:0] ctrl;
      int rd, wen, ld;
      @(negedge clk);
      dv = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rs1 = int'($urandom_range(0, 7)); rs2 = int'($urandom_range(0, 7));
      u1 = int'($urandom_range(0, 1)); u2 = int'($urandom_range(0, 1));
      rd = int'($urandom_range(0, 7)); wen = int'($urandom_range(0, 1));
      ld = ($urandom_range(0, 2) == 0) ? 1 : 0;
      imm = $urandom; pc = $urandom; ctrl = 16'($urandom);
      drive_dec(dv, rs1, rs2, u1, u2, rd, wen, ld, int'(imm), int'(pc), int'(ctrl));
      rf_a_data = regs[rs1]; rf_b_data = regs[rs2];
      ex_res_data = $urandom;
      mem_wen = 1'($urandom_range(0, 1)); mem_rd = 4'($urandom_range(0, 7));
      mem_data_vld = ($urandom_range(0, 3) != 0); mem_data = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = 4'($urandom_range(0, 7));
      wb_data = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);

      d1 = resolve(rs1, regs[rs1]);
      d2 = resolve(rs2, regs[rs2]);
      stall = waits_on(rs1, u1) || waits_on(rs2, u2);
      can_move = !m_valid || bus.out_ready;
      exp_rdy = (flush || (can_move && !stall)) ? 1 : 0;
      take = (dv != 0) && (exp_rdy != 0) && !flush;
      #1;
      chk($sformatf("rnd%0d dec_ready", c), 32'(bus.dec_ready), 32'(exp_rdy));
      @(posedge clk);
      if (flush) begin
        m_valid = 1'b0;
      end else if (can_move) begin
        m_valid = take;
        if (take) begin
          m_rd = rd; m_wen = wen; m_ld = ld;
          m_imm = imm; m_pc = pc; m_ctrl = ctrl; m_d1 = d1; m_d2 = d2;
        end
      end
      if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
      #1;
      chk($sformatf("rnd%0d out_valid", c), 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk($sformatf("rnd%0d rs1_data", c), bus.out_rs1_data, m_d1);
        chk($sformatf("rnd%0d rs2_data", c), bus.out_rs2_data, m_d2);
        chk($sformatf("rnd%0d rd", c), 32'(bus.out_rd), 32'(m_rd));
        chk($sformatf("rnd%0d wen", c), 32'(bus.out_wen), 32'(m_wen));
        chk($sformatf("rnd%0d is_load", c), 32'(bus.out_is_load), 32'(m_ld));
        chk($sformatf("rnd%0d imm", c), bus.out_imm, m_imm);
        chk($sformatf("rnd%0d pc", c), bus.out_pc, m_pc);
        chk($sformatf("rnd%0d ctrl", c), 32'(bus.out_ctrl), 32'(m_ctrl));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
